eth_rx_fifo: RTL
================

# eth_rx_fifo

Frame buffer sitting directly downstream of the MII receive stage, in the `rx_clk` domain. It captures the receive byte stream and strips the 4-byte FCS. Each frame is committed or discarded according to the receiver's frame-valid verdict. Committed frames are replayed to the protocol stack on a valid/ready byte stream with an end-of-frame marker.

## Interface
Parameters:
- P_ADDR_W, 11: buffer address width; depth 2^P_ADDR_W bytes, one slot always kept empty.
- P_MIN_LEN, 14: minimum payload bytes after FCS strip; shorter frames are dropped.
- P_MAX_LEN, 1514: maximum payload bytes; longer frames are dropped.
- P_VERDICT_CYC, 4: cycles after `rx_eof` to wait for `rx_frm_vld`.

Ports:
- rx_clk  in  1  sole clock for both write and read sides.
- rx_rst  in  1  asynchronous, active-high reset.
- rx_sof  in  1  start-of-frame pulse from the receiver.
- rx_eof  in  1  end-of-frame pulse; the last byte has already been presented.
- rx_byte_vld  in  1  `rx_byte` is captured on every cycle this is 1.
- rx_byte  in  8  received byte, FCS included.
- rx_frm_vld  in  1  sticky verdict: address and CRC good.
- rx_frm_ack  out  1  verdict consumed; clears `rx_frm_vld`.
- m_tdata  out  8  output byte.
- m_tvalid  out  1  `m_tdata` is valid.
- m_tlast  out  1  last payload byte of the frame.
- m_tready  in  1  downstream accepts the byte.
- frm_good_cnt  out  16  committed frame count (see Configuration).
- frm_drop_cnt  out  16  dropped frame count (see Configuration).

## Operation
- Buffer: 9-bit words {last, byte}. Three pointers:
  - `wr_ptr`: speculative write pointer.
  - `cmt_ptr`: committed end pointer.
  - `rd_ptr`: read pointer.
- FCS strip:
  - Captured bytes enter a 4-deep delay line; a byte is written only when it is shifted out.
  - The final 4 bytes are therefore never written.
  - The last written byte and its address are held in registers.
- Write FSM states:
  - W_IDLE: `rx_sof` → W_FRAME. Clear the delay line and the length counter. `wr_ptr` is already equal to `cmt_ptr`.
  - W_FRAME: capture bytes.
    - `rx_eof` → W_VERDICT. On the same cycle, rewrite the last written address with last=1.
    - `rx_sof` while in W_FRAME → drop the current frame by rewinding `wr_ptr` to `cmt_ptr`, then restart W_FRAME.
  - W_VERDICT: count up to P_VERDICT_CYC cycles.
    - Commit when `rx_frm_vld`=1, the frame is not flagged bad, and P_MIN_LEN ≤ len ≤ P_MAX_LEN: set `cmt_ptr` to `wr_ptr`, then → W_ACK.
    - Drop when the window expires or the frame is flagged bad: set `wr_ptr` to `cmt_ptr`, then → W_IDLE. If `rx_frm_vld`=1, go to W_ACK instead so the verdict is still consumed.
  - W_ACK: hold `rx_frm_ack`=1 until `rx_frm_vld` is sampled 0, then → W_IDLE. An `rx_sof` arriving in this state is also accepted (→ W_FRAME).
- Bad-frame flag is set by:
  - buffer full on a write (`wr_ptr`+1 == `rd_ptr` mod depth); further writes are suppressed;
  - payload length exceeding P_MAX_LEN.
- Frames whose length is 0 after the strip (fewer than 5 bytes) are always dropped; no last rewrite occurs.
- Length counter: 11 bits, saturating.
- Read side: when `rd_ptr` ≠ `cmt_ptr`, read the RAM into a 1-entry output register plus a 1-entry skid register, giving full throughput. `m_tlast` comes from the stored last bit.

## Timing
- Reset values:
  - `rx_frm_ack`, `m_tvalid`, `m_tlast`, `m_tdata` = 0;
  - all pointers = 0; FSM in W_IDLE;
  - both counters = 0.
- Reset mid-frame loses all uncommitted and unread data.
- Commit to first `m_tvalid`: 2 cycles (pointer compare, then RAM read). Back-to-back bytes thereafter while `m_tready`=1.
- `m_tvalid`/`m_tdata`/`m_tlast` stay stable while `m_tvalid`=1 and `m_tready`=0.
- Simultaneous write commit and read in the same cycle is legal. The full check uses the registered `rd_ptr`.
- Pointer wrap: modulo 2^P_ADDR_W, no special case.

## Configuration
- ETH_RX_FIFO_STATS_EN defined:
  - `frm_good_cnt` increments on each commit.
  - `frm_drop_cnt` increments on each drop.
  - Both are 16-bit saturating counters.
- ETH_RX_FIFO_STATS_EN undefined: both outputs are tied to 0 and no counter logic is generated.

## Structure
- Shared package `eth_pkg`:
  - C_FCS_LEN = 4;
  - the write FSM state enum (W_IDLE, W_FRAME, W_VERDICT, W_ACK);
  - C_MAX_FRAME = 1518.
- Sub-module `sdp_ram`: simple dual-port RAM, 9 bits × 2^P_ADDR_W, synchronous read with 1-cycle latency, write-first not required.

## Test plan
- 64-byte frame (60 payload + 4 FCS), `rx_frm_vld` rising 2 cycles after `rx_eof` → 60 bytes out, `m_tlast` on byte 60, `rx_frm_ack` held until `rx_frm_vld` drops, `frm_good_cnt`=1.
- Same frame with `rx_frm_vld` never asserted → no output, `wr_ptr` rewound, `frm_drop_cnt`=1.
- 10-byte frame (6 payload) with `rx_frm_vld`=1 → dropped (below P_MIN_LEN), ack still asserted.
- P_ADDR_W=6, `m_tready`=0, two 40-byte good frames → first committed, second overflows and is dropped; after `m_tready`=1 only the first frame's 36 bytes appear.
- `rx_sof` mid-frame after 20 bytes, then a full 64-byte good frame → only the second frame's 60 bytes are output.
- Good frames spanning the pointer wrap, with random `m_tready` backpressure → byte-exact output, stable data during stalls.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared constants and write-FSM state type for the Ethernet receive frame buffer.
package eth_pkg;

  localparam int unsigned C_FCS_LEN   = 4;
  localparam int unsigned C_MAX_FRAME = 1518;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_FRAME   = 2'd1,
    W_VERDICT = 2'd2,
    W_ACK     = 2'd3
  } w_state_e;

endpackage

// File: rtl/eth_rx_fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port (1-cycle latency).
module sdp_ram
  import eth_pkg::*;
#(
  parameter int P_ADDR_W = 11,
  parameter int P_DATA_W = 9
) (
  input  logic                clk_i,
  input  logic                we_i,
  input  logic [P_ADDR_W-1:0] waddr_i,
  input  logic [P_DATA_W-1:0] wdata_i,
  input  logic                re_i,
  input  logic [P_ADDR_W-1:0] raddr_i,
  output logic [P_DATA_W-1:0] rdata_o
);

  logic [P_DATA_W-1:0] mem_q [2**P_ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/eth_rx_fifo.sv
// Receive frame buffer: strips FCS, commits/drops frames on the receiver verdict, replays as a byte stream.
// Optional frame statistics counters are enabled with ETH_RX_FIFO_STATS_EN.
module eth_rx_fifo
  import eth_pkg::*;
#(
  parameter int P_ADDR_W      = 11,
  parameter int P_MIN_LEN     = 14,
  parameter int P_MAX_LEN     = 1514,
  parameter int P_VERDICT_CYC = 4
) (
  input  logic        rx_clk,
  input  logic        rx_rst,
  input  logic        rx_sof,
  input  logic        rx_eof,
  input  logic        rx_byte_vld,
  input  logic [7:0]  rx_byte,
  input  logic        rx_frm_vld,
  output logic        rx_frm_ack,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  input  logic        m_tready,
  output logic [15:0] frm_good_cnt,
  output logic [15:0] frm_drop_cnt
);

  localparam logic [10:0]         C_MIN_LEN  = 11'(P_MIN_LEN);
  localparam logic [10:0]         C_MAX_LEN  = 11'(P_MAX_LEN);
  localparam logic [7:0]          C_VCYC_END = 8'(P_VERDICT_CYC - 1);
  localparam logic [2:0]          C_DL_FULL  = 3'(C_FCS_LEN);
  localparam logic [P_ADDR_W-1:0] C_PTR_ONE  = {{(P_ADDR_W-1){1'b0}}, 1'b1};

  w_state_e            state_q, state_d;
  logic [P_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [P_ADDR_W-1:0] cmt_ptr_q, cmt_ptr_d;
  logic [P_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]          dl_q [C_FCS_LEN];
  logic [7:0]          dl_d [C_FCS_LEN];
  logic [2:0]          dl_cnt_q, dl_cnt_d;
  logic [10:0]         len_q, len_d;
  logic                bad_q, bad_d;
  logic [P_ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [7:0]          last_byte_q, last_byte_d;
  logic [7:0]          vcnt_q, vcnt_d;

  logic                ram_we;
  logic [P_ADDR_W-1:0] ram_waddr;
  logic [8:0]          ram_wdata;
  logic [8:0]          ram_rdata;
  logic                commit, drop, start, full, len_ok;

  logic [8:0]          out_q, out_d, skid_q, skid_d;
  logic                out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic                rd_pend_q, rd_pend_d;
  logic                pop, issue;
  logic [1:0]          occ;

  assign full   = (wr_ptr_q + C_PTR_ONE) == rd_ptr_q;
  assign len_ok = (len_q >= C_MIN_LEN) && (len_q <= C_MAX_LEN);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cmt_ptr_d   = cmt_ptr_q;
    dl_d        = dl_q;
    dl_cnt_d    = dl_cnt_q;
    len_d       = len_q;
    bad_d       = bad_q;
    last_addr_d = last_addr_q;
    last_byte_d = last_byte_q;
    vcnt_d      = vcnt_q;
    ram_we      = 1'b0;
    ram_waddr   = wr_ptr_q;
    ram_wdata   = {1'b0, dl_q[C_FCS_LEN-1]};
    commit      = 1'b0;
    drop        = 1'b0;
    start       = 1'b0;

    case (state_q)
      W_IDLE: begin
        if (rx_sof) start = 1'b1;
      end
      W_FRAME: begin
        if (rx_sof) begin
          drop     = 1'b1;
          wr_ptr_d = cmt_ptr_q;
          start    = 1'b1;
        end else if (rx_eof) begin
          state_d = W_VERDICT;
          vcnt_d  = '0;
          if ((len_q != '0) && !bad_q) begin
            ram_we    = 1'b1;
            ram_waddr = last_addr_q;
            ram_wdata = {1'b1, last_byte_q};
          end
        end else if (rx_byte_vld) begin
          for (int unsigned i = C_FCS_LEN - 1; i > 0; i--) dl_d[i] = dl_q[i-1];
          dl_d[0] = rx_byte;
          if (dl_cnt_q == C_DL_FULL) begin
            // Oldest delay-line byte is payload, so it leaves for the RAM now.
            if (len_q != '1) len_d = len_q + 11'd1;
            if (len_q >= C_MAX_LEN) bad_d = 1'b1;
            if (full) bad_d = 1'b1;
            if (!full && !bad_q) begin
              ram_we      = 1'b1;
              wr_ptr_d    = wr_ptr_q + C_PTR_ONE;
              last_addr_d = wr_ptr_q;
              last_byte_d = dl_q[C_FCS_LEN-1];
            end
          end else begin
            dl_cnt_d = dl_cnt_q + 3'd1;
          end
        end
      end
      W_VERDICT: begin
        if (bad_q) begin
          drop     = 1'b1;
          wr_ptr_d = cmt_ptr_q;
          state_d  = rx_frm_vld ? W_ACK : W_IDLE;
        end else if (rx_frm_vld) begin
          if (len_ok) begin
            commit    = 1'b1;
            cmt_ptr_d = wr_ptr_q;
          end else begin
            drop     = 1'b1;
            wr_ptr_d = cmt_ptr_q;
          end
          state_d = W_ACK;
        end else if (vcnt_q == C_VCYC_END) begin
          drop     = 1'b1;
          wr_ptr_d = cmt_ptr_q;
          state_d  = W_IDLE;
        end else begin
          vcnt_d = vcnt_q + 8'd1;
        end
      end
      W_ACK: begin
        if (rx_sof) start = 1'b1;
        else if (!rx_frm_vld) state_d = W_IDLE;
      end
      default: state_d = W_IDLE;
    endcase

    if (start) begin
      state_d  = W_FRAME;
      dl_cnt_d = '0;
      len_d    = '0;
      bad_d    = 1'b0;
    end
  end

  // Read side: output register plus skid register, counting the in-flight RAM read as occupancy.
  assign pop   = out_vld_q && m_tready;
  assign occ   = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(rd_pend_q) - 2'(pop);
  assign issue = (rd_ptr_q != cmt_ptr_q) && (occ < 2'd2);

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    rd_pend_d  = issue;
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (issue) rd_ptr_d = rd_ptr_q + C_PTR_ONE;

    if (pop || !out_vld_q) begin
      if (skid_vld_q) begin
        out_d     = skid_q;
        out_vld_d = 1'b1;
        if (rd_pend_q) skid_d = ram_rdata;
        else skid_vld_d = 1'b0;
      end else if (rd_pend_q) begin
        out_d     = ram_rdata;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (rd_pend_q) begin
      skid_d     = ram_rdata;
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      state_q     <= W_IDLE;
      wr_ptr_q    <= '0;
      cmt_ptr_q   <= '0;
      rd_ptr_q    <= '0;
      for (int unsigned i = 0; i < C_FCS_LEN; i++) dl_q[i] <= '0;
      dl_cnt_q    <= '0;
      len_q       <= '0;
      bad_q       <= 1'b0;
      last_addr_q <= '0;
      last_byte_q <= '0;
      vcnt_q      <= '0;
      out_q       <= '0;
      out_vld_q   <= 1'b0;
      skid_q      <= '0;
      skid_vld_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cmt_ptr_q   <= cmt_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      dl_q        <= dl_d;
      dl_cnt_q    <= dl_cnt_d;
      len_q       <= len_d;
      bad_q       <= bad_d;
      last_addr_q <= last_addr_d;
      last_byte_q <= last_byte_d;
      vcnt_q      <= vcnt_d;
      out_q       <= out_d;
      out_vld_q   <= out_vld_d;
      skid_q      <= skid_d;
      skid_vld_q  <= skid_vld_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  sdp_ram #(
    .P_ADDR_W (P_ADDR_W),
    .P_DATA_W (9)
  ) u_ram (
    .clk_i   (rx_clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (issue),
    .raddr_i (rd_ptr_q),
    .rdata_o (ram_rdata)
  );

  assign rx_frm_ack = (state_q == W_ACK);
  assign m_tdata    = out_q[7:0];
  assign m_tlast    = out_q[8];
  assign m_tvalid   = out_vld_q;

`ifdef ETH_RX_FIFO_STATS_EN
  logic [15:0] good_cnt_q, drop_cnt_q;

  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      good_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (commit && (good_cnt_q != '1)) good_cnt_q <= good_cnt_q + 16'd1;
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign frm_good_cnt = good_cnt_q;
  assign frm_drop_cnt = drop_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = commit ^ drop;
  assign frm_good_cnt = '0;
  assign frm_drop_cnt = '0;
`endif

endmodule
